data_mem_responder: RTL
=======================

# data_mem_responder

Wait-state data memory responder: the target end of the CPU data-memory bus (DAddr/DataIn/nRD/nWR/Dataout). Accepts one read or write per request, inserts a programmable number of wait cycles, then answers with a one-cycle Ready pulse. It replaces the zero-latency data memory in multi-cycle builds and lets CPU stall logic be tested against a slow memory. Storage is a byte array read and written as 32-bit big-endian words.

## Interface
- DEPTH_BYTES, 128: storage size in bytes; a multiple of 4, at most 4096.
- WAIT_CYCLES, 2: wait cycles inserted before the access; legal range 0..15.
- CLK  in  1  clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-high reset (polarity and synchronicity fixed for this block).
- DAddr  in  32  byte address of the request.
- DataIn  in  32  write data.
- nRD  in  1  read strobe, active low.
- nWR  in  1  write strobe, active low.
- Dataout  out  32  read data; registered; valid while Ready=1 and held afterwards.
- Ready  out  1  one-cycle completion pulse.
- Busy  out  1  high whenever the FSM is not in IDLE.
- AddrErr  out  1  high together with Ready when the request was rejected.

## Operation
- FSM states: IDLE, WAIT, ACCESS, RELEASE. Reset forces IDLE, Dataout=0, Ready=0, Busy=0, AddrErr=0, wait counter=0, and all storage bytes to 0x00.
- IDLE: a request is present when nRD=0 or nWR=0.
  - On that edge the block captures DAddr, DataIn and the op. Write has priority when both strobes are low.
  - Next state is WAIT with counter=WAIT_CYCLES, or ACCESS if WAIT_CYCLES=0.
- WAIT: counter decrements each edge. The transition to ACCESS happens on the edge where counter=1. Strobe and address changes are ignored; captured values are used.
- ACCESS: one edge that performs the access and sets Ready=1.
  - Error when captured addr[1:0]≠0 or addr > DEPTH_BYTES−4 (full 32-bit compare, no wrap).
  - On error: no storage change, Dataout=0, AddrErr=1.
  - Write with no error: mem[a]=DataIn[31:24], mem[a+1]=DataIn[23:16], mem[a+2]=DataIn[15:8], mem[a+3]=DataIn[7:0]. Dataout is unchanged.
  - Read with no error: Dataout={mem[a],mem[a+1],mem[a+2],mem[a+3]}.
  - Next state is RELEASE.
- RELEASE: Ready and AddrErr drop after one cycle. The FSM stays here until nRD=1 and nWR=1 are sampled on the same edge, then returns to IDLE. This prevents a held strobe from being taken as a second request.
- Busy=1 in WAIT, ACCESS and RELEASE.

## Timing
- Request sampled at edge E0 in IDLE. Ready=1 during the cycle after edge E0+WAIT_CYCLES+1, for exactly one cycle.
- Read data becomes visible on Dataout at the same edge that raises Ready.
- Back-to-back throughput: strobes released in the Ready cycle → IDLE at E0+WAIT_CYCLES+3. Fastest request spacing is WAIT_CYCLES+3 cycles.
- Reset mid-operation (WAIT or ACCESS pending): the access is aborted, no write is committed, outputs return to reset values on the same edge.
- Reset on the ACCESS edge takes precedence over the access.
- Reset has priority over every other input on every edge.

## Test plan
- Reset, then read 0x0000_0004 with WAIT_CYCLES=2 → Ready pulses exactly 3 cycles after the capture edge, Dataout=0x0000_0000, AddrErr=0, Busy high from capture until return to IDLE.
- Write 0x1122_3344 to 0x10, release strobes, then read 0x10 → Dataout=0x1122_3344. A separate byte-level probe shows mem[0x10]=0x11 and mem[0x13]=0x44.
- Misaligned read 0x0000_0006, then out-of-range write to DEPTH_BYTES → each gives a Ready pulse with AddrErr=1 and Dataout=0. A subsequent read of 0x04 returns its previously written value unchanged.
- Hold nRD low for 10 cycles after Ready → only one Ready pulse. The FSM stays in RELEASE with Busy=1 until nRD rises, then returns to IDLE.
- nRD=0 and nWR=0 together with DAddr=0x20, DataIn=0xDEAD_BEEF → treated as a write. Dataout is unchanged, and a later read of 0x20 returns 0xDEAD_BEEF.
- Start a write to 0x08 and assert Reset during WAIT → Ready never pulses, all outputs are 0 after the reset edge, and a later read of 0x08 returns 0x0000_0000.
  - Rerun the first scenario with WAIT_CYCLES=0 → Ready appears at E0+1.

Source files
------------

// File: rtl/data_mem_responder_if.sv
// Data-memory bus between the CPU (master) and a wait-state memory responder (slave).
interface data_mem_responder_if;
  logic [31:0] DAddr;
  logic [31:0] DataIn;
  logic        nRD;
  logic        nWR;
  logic [31:0] Dataout;
  logic        Ready;
  logic        Busy;
  logic        AddrErr;

  modport master (
    output DAddr, DataIn, nRD, nWR,
    input  Dataout, Ready, Busy, AddrErr
  );

  modport slave (
    input  DAddr, DataIn, nRD, nWR,
    output Dataout, Ready, Busy, AddrErr
  );
endinterface

// File: rtl/data_mem_responder.sv
// Wait-state data memory: captures one request, waits WAIT_CYCLES, performs a big-endian
// word access to a byte array and answers with a one-cycle Ready pulse.
//
// state     | meaning
// S_IDLE    | waiting for nRD=0 or nWR=0
// S_WAIT    | counting down programmed wait cycles
// S_ACCESS  | one edge: perform access, raise Ready
// S_RELEASE | hold off until both strobes are high
module data_mem_responder #(
  parameter int DEPTH_BYTES = 128,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                CLK,
  input  logic                Reset,
  data_mem_responder_if.slave bus
);

  localparam int AW = $clog2(DEPTH_BYTES);
  localparam logic [31:0] LAST_WORD = 32'(DEPTH_BYTES - 4);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RELEASE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        is_wr_q;
  logic [31:0] dout_q;
  logic        ready_q;
  logic        err_q;
  logic [7:0]  mem_q [DEPTH_BYTES];

  logic          capture;
  logic          do_access;
  logic          addr_err;
  logic [AW-1:0] a0, a1, a2, a3;

  // Full 32-bit compare: addresses above the array never wrap into it.
  assign addr_err = (addr_q[1:0] != 2'b00) || (addr_q > LAST_WORD);
  assign a0 = {addr_q[AW-1:2], 2'b00};
  assign a1 = {addr_q[AW-1:2], 2'b01};
  assign a2 = {addr_q[AW-1:2], 2'b10};
  assign a3 = {addr_q[AW-1:2], 2'b11};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    capture   = 1'b0;
    do_access = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!bus.nRD || !bus.nWR) begin
          capture = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_d = S_ACCESS;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_CYCLES);
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_ACCESS;
      end
      S_ACCESS: begin
        do_access = 1'b1;
        state_d   = S_RELEASE;
      end
      S_RELEASE: begin
        if (bus.nRD && bus.nWR) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      is_wr_q <= 1'b0;
      dout_q  <= 32'd0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < DEPTH_BYTES; i++) mem_q[i] <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= do_access;
      err_q   <= do_access && addr_err;
      if (capture) begin
        addr_q  <= bus.DAddr;
        wdata_q <= bus.DataIn;
        is_wr_q <= !bus.nWR;
      end
      if (do_access) begin
        if (addr_err) begin
          dout_q <= 32'd0;
        end else if (is_wr_q) begin
          mem_q[a0] <= wdata_q[31:24];
          mem_q[a1] <= wdata_q[23:16];
          mem_q[a2] <= wdata_q[15:8];
          mem_q[a3] <= wdata_q[7:0];
        end else begin
          dout_q <= {mem_q[a0], mem_q[a1], mem_q[a2], mem_q[a3]};
        end
      end
    end
  end

  assign bus.Dataout = dout_q;
  assign bus.Ready   = ready_q;
  assign bus.AddrErr = err_q;
  assign bus.Busy    = (state_q != S_IDLE);

endmodule
